// File: rtl/servo_ramp_if.sv
// Command bus between the register block / PWM generator and servo_ramp.
// Latency: n/a (signal bundle only).
// Flow control: none; target_valid is a single-cycle strobe, outputs are levels.
// Ports: master = register side + PWM sink, slave = servo_ramp.
interface servo_ramp_if #(
  parameter int W      = 24,
  parameter int STEP_W = 16
);
  logic              enable;
  logic [W-1:0]      period;
  logic [W-1:0]      pulse_min;
  logic [W-1:0]      pulse_max;
  logic [STEP_W-1:0] slew_step;
  logic [W-1:0]      target;
  logic              target_valid;
  logic [W-1:0]      period_out;
  logic [W-1:0]      pulse_out;
  logic              frame_tick;
  logic              busy;
  logic              reached;

  modport master (
    output enable, period, pulse_min, pulse_max, slew_step, target, target_valid,
    input  period_out, pulse_out, frame_tick, busy, reached
  );

  modport slave (
    input  enable, period, pulse_min, pulse_max, slew_step, target, target_valid,
    output period_out, pulse_out, frame_tick, busy, reached
  );
endinterface

// File: rtl/servo_ramp.sv
// Servo command stage: clamps the target, slews pulse_out toward it per PWM frame.
// Latency: outputs update only on the clock edge ending a frame_tick cycle.
// Flow control: none; a new target may arrive any cycle, last strobe wins.
// Ports: clk, reset_n (async active-low); bus = servo_ramp_if slave modport
//        (enable/period/limits/step/target in, period_out/pulse_out/flags out).
module servo_ramp #(
  parameter int W      = 24,
  parameter int STEP_W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  servo_ramp_if.slave  bus
);

  typedef enum logic [1:0] {S_DISABLED, S_HOLD, S_RAMP} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] frame_cnt, frame_cnt_nxt;
  logic [W-1:0] period_lat, period_lat_nxt;
  logic [W-1:0] target_reg, target_hi_clip, target_clamped;
  logic [W-1:0] period_q, period_nxt;
  logic [W-1:0] pulse_q, pulse_nxt;
  logic         tick_q, reached_q, reached_nxt;
  logic [W:0]   diff, step_wide;
  logic [W-1:0] step_ext;
  logic         move_up, arrive, do_step;

  // Clamp: upper bound first, then lower bound, so min > max resolves to min.
  always_comb begin
    target_hi_clip = (bus.target > bus.pulse_max) ? bus.pulse_max : bus.target;
    target_clamped = (target_hi_clip < bus.pulse_min) ? bus.pulse_min : target_hi_clip;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              target_reg <= '0;
    else if (bus.target_valid) target_reg <= target_clamped;
  end

  // Frame counter wraps on its own compare so it can never run away, while
  // period_lat only reloads on a frame_tick edge. frame_tick is registered
  // from the next-cycle compare, so it is high exactly when cnt == lat.
  always_comb begin
    frame_cnt_nxt  = (frame_cnt == period_lat) ? '0 : frame_cnt + W'(1);
    period_lat_nxt = tick_q ? bus.period : period_lat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt  <= '0;
      period_lat <= '0;
      tick_q     <= 1'b0;
    end else begin
      frame_cnt  <= frame_cnt_nxt;
      period_lat <= period_lat_nxt;
      tick_q     <= (frame_cnt_nxt == period_lat_nxt);
    end
  end

  // Distance to target in W+1 bits; the step is zero-extended.
  always_comb begin
    move_up   = (target_reg > pulse_q);
    diff      = move_up ? ({1'b0, target_reg} - {1'b0, pulse_q})
                        : ({1'b0, pulse_q} - {1'b0, target_reg});
    step_wide = {{(W + 1 - STEP_W){1'b0}}, bus.slew_step};
    step_ext  = {{(W - STEP_W){1'b0}}, bus.slew_step};
    arrive    = (bus.slew_step == '0) || (diff <= step_wide);
  end

  always_comb begin
    state_nxt   = state;
    pulse_nxt   = pulse_q;
    period_nxt  = period_q;
    reached_nxt = 1'b0;
    do_step     = 1'b0;
    if (tick_q) begin
      case (state)
        S_DISABLED: begin
          if (bus.enable) begin
            // No known prior position: jump straight to the target.
            pulse_nxt   = target_reg;
            period_nxt  = bus.period;
            reached_nxt = 1'b1;
            state_nxt   = S_HOLD;
          end
        end
        S_HOLD, S_RAMP: begin
          if (!bus.enable) begin
            pulse_nxt  = '0;
            period_nxt = '0;
            state_nxt  = S_DISABLED;
          end else begin
            period_nxt = bus.period;
            do_step    = (state == S_RAMP) || (target_reg != pulse_q);
          end
        end
        default: state_nxt = S_DISABLED;
      endcase
    end
    if (do_step) begin
      if (arrive) begin
        pulse_nxt   = target_reg;
        reached_nxt = 1'b1;
        state_nxt   = S_HOLD;
      end else begin
        pulse_nxt = move_up ? (pulse_q + step_ext) : (pulse_q - step_ext);
        state_nxt = S_RAMP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_DISABLED;
      pulse_q   <= '0;
      period_q  <= '0;
      reached_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_q   <= pulse_nxt;
      period_q  <= period_nxt;
      reached_q <= reached_nxt;
    end
  end

  assign bus.period_out = period_q;
  assign bus.pulse_out  = pulse_q;
  assign bus.frame_tick = tick_q;
  assign bus.reached    = reached_q;
  assign bus.busy       = (state != S_DISABLED) && (pulse_q != target_reg);

endmodule
